// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, FSM states and mux/ALU codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_HALT    = 4'd12
  } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp and the instruction funct field to an ALU control code.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_funct_legal
);

  always_comb begin
    o_alu_control = ALU_ADD;
    o_funct_legal = 1'b1;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_control = ALU_ADD;
          FN_SUB:  o_alu_control = ALU_SUB;
          FN_AND:  o_alu_control = ALU_AND;
          FN_OR:   o_alu_control = ALU_OR;
          FN_SLT:  o_alu_control = ALU_SLT;
          default: o_funct_legal = 1'b0;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main controller for the multicycle MIPS datapath: Moore FSM whose outputs decode from the
// registered state (plus Funct/Zero), with every strobe and select held low while RST is high.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int ILLEGAL_TRAP = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       IllegalOp,
  output logic       InstrDone,
  output logic [3:0] State
);

  state_t     r_state;
  state_t     w_next;
  state_t     w_illegal_next;
  logic [1:0] w_alu_op;
  logic [2:0] w_alu_ctl;
  logic       w_funct_legal;
  logic       w_pc_write;
  logic       w_branch;

  mips_alu_decoder u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct       (Funct),
    .o_alu_control (w_alu_ctl),
    .o_funct_legal (w_funct_legal)
  );

  assign w_illegal_next = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
  assign State          = r_state;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          default:      w_next = w_illegal_next;
        endcase
      end
      S_MEMADR:  w_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = S_MEMWB;
      S_RTYPEEX: w_next = w_funct_legal ? S_RTYPEWB : w_illegal_next;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_write = 1'b0;
    w_branch   = 1'b0;
    w_alu_op   = ALUOP_ADD;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    PCSrc      = PCSRC_ALU;
    IllegalOp  = 1'b0;
    InstrDone  = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcB    = SRCB_4;
        w_pc_write = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        case (Opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: IllegalOp = 1'b0;
          default: IllegalOp = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_RTYPEEX: begin
        ALUSrcA   = 1'b1;
        w_alu_op  = ALUOP_FUNCT;
        IllegalOp = ~w_funct_legal;
      end
      S_RTYPEWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
      end
      S_BEQEX: begin
        ALUSrcA   = 1'b1;
        w_alu_op  = ALUOP_SUB;
        PCSrc     = PCSRC_ALUOUT;
        w_branch  = 1'b1;
        InstrDone = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDIWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_JEX: begin
        PCSrc      = PCSRC_JUMP;
        w_pc_write = 1'b1;
        InstrDone  = 1'b1;
      end
      default: ;
    endcase
    ALUControl = w_alu_ctl;
    PCEn       = w_pc_write | (w_branch & Zero);
    // Reset overrides everything so an abandoned instruction can never strobe a write.
    if (RST) begin
      PCEn       = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = 3'b000;
      PCSrc      = 2'b00;
      IllegalOp  = 1'b0;
      InstrDone  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS controller: per-cycle vector table plus reset/trap sequences.
module tb_mips_multicycle_control;

  logic       CLK, RST, Zero;
  logic [5:0] Opcode, Funct;

  logic       PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, IllegalOp, InstrDone;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  logic       t_PCEn, t_IorD, t_MemWrite, t_IRWrite, t_RegWrite, t_RegDst, t_MemtoReg, t_ALUSrcA;
  logic       t_IllegalOp, t_InstrDone;
  logic [1:0] t_ALUSrcB, t_PCSrc;
  logic [2:0] t_ALUControl;
  logic [3:0] t_State;

  mips_multicycle_control #(.ILLEGAL_TRAP(0)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .IllegalOp(IllegalOp), .InstrDone(InstrDone),
    .State(State)
  );

  mips_multicycle_control #(.ILLEGAL_TRAP(1)) dut_trap (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCEn(t_PCEn), .IorD(t_IorD), .MemWrite(t_MemWrite), .IRWrite(t_IRWrite), .RegWrite(t_RegWrite),
    .RegDst(t_RegDst), .MemtoReg(t_MemtoReg), .ALUSrcA(t_ALUSrcA), .ALUSrcB(t_ALUSrcB),
    .ALUControl(t_ALUControl), .PCSrc(t_PCSrc), .IllegalOp(t_IllegalOp), .InstrDone(t_InstrDone),
    .State(t_State)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Field order: PCEn,IorD,MemWrite,IRWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUControl,PCSrc,IllegalOp,InstrDone
  localparam logic [16:0] E_RST     = 17'b0;
  localparam logic [16:0] E_FETCH   = {8'b1001_0000, 2'b01, 3'b010, 2'b00, 2'b00};
  localparam logic [16:0] E_DEC     = {8'b0000_0000, 2'b11, 3'b010, 2'b00, 2'b00};
  localparam logic [16:0] E_DEC_ILL = {8'b0000_0000, 2'b11, 3'b010, 2'b00, 2'b10};
  localparam logic [16:0] E_MEMADR  = {8'b0000_0001, 2'b10, 3'b010, 2'b00, 2'b00};
  localparam logic [16:0] E_MEMRD   = {8'b0100_0000, 2'b00, 3'b010, 2'b00, 2'b00};
  localparam logic [16:0] E_MEMWB   = {8'b0000_1010, 2'b00, 3'b010, 2'b00, 2'b01};
  localparam logic [16:0] E_MEMWR   = {8'b0110_0000, 2'b00, 3'b010, 2'b00, 2'b01};
  localparam logic [16:0] E_REX_SLT = {8'b0000_0001, 2'b00, 3'b111, 2'b00, 2'b00};
  localparam logic [16:0] E_REX_SUB = {8'b0000_0001, 2'b00, 3'b110, 2'b00, 2'b00};
  localparam logic [16:0] E_REX_BAD = {8'b0000_0001, 2'b00, 3'b010, 2'b00, 2'b10};
  localparam logic [16:0] E_RWB     = {8'b0000_1100, 2'b00, 3'b010, 2'b00, 2'b01};
  localparam logic [16:0] E_BEQ_T   = {8'b1000_0001, 2'b00, 3'b110, 2'b01, 2'b01};
  localparam logic [16:0] E_BEQ_N   = {8'b0000_0001, 2'b00, 3'b110, 2'b01, 2'b01};
  localparam logic [16:0] E_ADDIEX  = {8'b0000_0001, 2'b10, 3'b010, 2'b00, 2'b00};
  localparam logic [16:0] E_ADDIWB  = {8'b0000_1000, 2'b00, 3'b010, 2'b00, 2'b01};
  localparam logic [16:0] E_J       = {8'b1000_0000, 2'b00, 3'b010, 2'b10, 2'b01};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, ILL = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [3:0]  st;
    logic [16:0] o;
  } vec_t;

  vec_t vecs[$];
  int   ncmp = 0;
  int   nbad = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic [3:0] st, input logic [16:0] o);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.z = z; v.st = st; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [16:0] outs();
    return {PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
            ALUSrcB, ALUControl, PCSrc, IllegalOp, InstrDone};
  endfunction

  function automatic logic [5:0] t_enables();
    return {t_PCEn, t_MemWrite, t_IRWrite, t_RegWrite, t_IllegalOp, t_InstrDone};
  endfunction

  initial begin
    // reset, then lw / sw / slt / addi / beq taken+not / j / sub / bad funct / bad opcode
    add(1, LW, 0, 0, 0, E_RST);    add(1, LW, 0, 0, 0, E_RST);
    add(0, LW, 0, 0, 0, E_FETCH);  add(0, LW, 0, 0, 1, E_DEC);    add(0, LW, 0, 0, 2, E_MEMADR);
    add(0, LW, 0, 0, 3, E_MEMRD);  add(0, LW, 0, 0, 4, E_MEMWB);
    add(0, SW, 0, 0, 0, E_FETCH);  add(0, SW, 0, 0, 1, E_DEC);    add(0, SW, 0, 0, 2, E_MEMADR);
    add(0, SW, 0, 0, 5, E_MEMWR);
    add(0, RT, 6'b101010, 0, 0, E_FETCH);   add(0, RT, 6'b101010, 0, 1, E_DEC);
    add(0, RT, 6'b101010, 0, 6, E_REX_SLT); add(0, RT, 6'b101010, 0, 7, E_RWB);
    add(0, ADDI, 0, 0, 0, E_FETCH); add(0, ADDI, 0, 0, 1, E_DEC);
    add(0, ADDI, 0, 0, 9, E_ADDIEX); add(0, ADDI, 0, 0, 10, E_ADDIWB);
    add(0, BEQ, 0, 1, 0, E_FETCH); add(0, BEQ, 0, 1, 1, E_DEC);   add(0, BEQ, 0, 1, 8, E_BEQ_T);
    add(0, BEQ, 0, 0, 0, E_FETCH); add(0, BEQ, 0, 0, 1, E_DEC);   add(0, BEQ, 0, 0, 8, E_BEQ_N);
    add(0, JMP, 0, 0, 0, E_FETCH); add(0, JMP, 0, 0, 1, E_DEC);   add(0, JMP, 0, 0, 11, E_J);
    add(0, RT, 6'b100010, 0, 0, E_FETCH);   add(0, RT, 6'b100010, 0, 1, E_DEC);
    add(0, RT, 6'b100010, 0, 6, E_REX_SUB); add(0, RT, 6'b100010, 0, 7, E_RWB);
    add(0, RT, 6'b111111, 0, 0, E_FETCH);   add(0, RT, 6'b111111, 0, 1, E_DEC);
    add(0, RT, 6'b111111, 0, 6, E_REX_BAD); add(0, RT, 6'b111111, 0, 0, E_FETCH);
    add(0, ILL, 0, 0, 1, E_DEC_ILL); add(0, ILL, 0, 0, 0, E_FETCH);

    RST = 1'b1; Opcode = LW; Funct = 6'b0; Zero = 1'b0;
    step();
    foreach (vecs[i]) begin
      RST = vecs[i].rst; Opcode = vecs[i].op; Funct = vecs[i].fn; Zero = vecs[i].z;
      #1;
      chk($sformatf("row%0d State", i), {28'b0, State}, {28'b0, vecs[i].st});
      chk($sformatf("row%0d outputs", i), {15'b0, outs()}, {15'b0, vecs[i].o});
      step();
    end

    // Reset while a lw sits in MEMRD: no writeback may leak out.
    RST = 1'b1; Opcode = LW; step();
    RST = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("lwabort c%0d State", c), {28'b0, State}, c);
      chk($sformatf("lwabort c%0d RegWrite", c), {31'b0, RegWrite}, 0);
      step();
    end
    chk("lwabort in MEMRD", {28'b0, State}, 3);
    RST = 1'b1; #1;
    chk("lwabort RegWrite under RST", {31'b0, RegWrite}, 0);
    step();
    chk("lwabort State after RST", {28'b0, State}, 0);
    RST = 1'b0; #1;
    chk("lwabort refetch IRWrite", {31'b0, IRWrite}, 1);
    chk("lwabort refetch RegWrite", {31'b0, RegWrite}, 0);

    // Trapping variant: illegal opcode parks in HALT until reset.
    RST = 1'b1; step();
    RST = 1'b0; Opcode = ILL; #1;
    chk("trap FETCH", {28'b0, t_State}, 0);
    step();
    chk("trap DECODE", {28'b0, t_State}, 1);
    chk("trap IllegalOp", {31'b0, t_IllegalOp}, 1);
    step();
    chk("notrap back to FETCH", {28'b0, State}, 0);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("trap halt c%0d State", c), {28'b0, t_State}, 12);
      chk($sformatf("trap halt c%0d enables", c), {26'b0, t_enables()}, 0);
      step();
    end
    RST = 1'b1; step();
    chk("trap State after RST", {28'b0, t_State}, 0);
    RST = 1'b0; #1;
    chk("trap FETCH after RST IRWrite", {31'b0, t_IRWrite}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
